// File: rtl/fs_pkg.sv
// Shared types and helpers for the Floyd-Steinberg error diffuser.
package fs_pkg;

  localparam int unsigned ErrW   = 11;
  localparam int unsigned Thresh = 128;
  localparam int          PixMax = 255;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StRowEnd,
    StDrain,
    StDone
  } fs_state_e;

  typedef logic signed [ErrW-1:0] err_t;

  // Clamp to the symmetric range +/-(2^(w-1)-1).
  function automatic int sat_err(input int v, input int unsigned w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/fs_err_linebuf.sv
// Ping-pong error line buffer: two banks of IMAGEX signed error terms,
// combinational read, single synchronous write, storage not reset.
module fs_err_linebuf #(
  parameter int unsigned IMAGEX = 256,
  parameter int unsigned ERR_W  = 11,
  localparam int unsigned XW    = (IMAGEX > 1) ? $clog2(IMAGEX) : 1
) (
  input  logic                    clk,
  input  logic                    rd_bank,
  input  logic [XW-1:0]           rd_addr,
  output logic signed [ERR_W-1:0] rd_data,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [XW-1:0]           wr_addr,
  input  logic signed [ERR_W-1:0] wr_data
);

  logic signed [ERR_W-1:0] mem_q [2][IMAGEX];

  assign rd_data = mem_q[rd_bank][rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/fs_error_diffuser.sv
// Floyd-Steinberg dithering core: 8-bit raster pixels in, one dithered bit out per pixel,
// error pushed 7/16 right, 3/16 bottom-left, 5/16 bottom, 1/16 bottom-right.
module fs_error_diffuser
  import fs_pkg::*;
#(
  parameter int unsigned IMAGEX   = 256,
  parameter int unsigned IMAGEY   = 256,
  parameter int unsigned RGB_SIZE = 8,
  parameter int unsigned ERR_W    = ErrW,
  parameter int unsigned THRESH   = Thresh
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RGB_SIZE-1:0] in_pixel,
  output logic                trav_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic                busy,
  output logic                done
);

  localparam int unsigned XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int unsigned YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] YLast = YW'(IMAGEY - 1);

  fs_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic sel_q, sel_d;
  logic signed [ERR_W-1:0] e_r_q, e_r_d, acc_b_q, acc_b_d, acc_bl_q, acc_bl_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d;

  logic signed [ERR_W-1:0] cur_err, pix_sum, pix_err, t7, t5, t3, t1, nxt_sum, acc_bl_new;
  logic q;
  logic accept;

  logic                    wr_en, wr_bank;
  logic [XW-1:0]           wr_addr;
  logic signed [ERR_W-1:0] wr_data;

  fs_err_linebuf #(
    .IMAGEX(IMAGEX),
    .ERR_W (ERR_W)
  ) u_linebuf (
    .clk    (clk),
    .rd_bank(sel_q),
    .rd_addr(x_q),
    .rd_data(cur_err),
    .wr_en  (wr_en),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign trav_en   = accept;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Every intermediate term is clamped to ERR_W before it feeds the next step.
  always_comb begin
    pix_sum    = ERR_W'(sat_err(int'(in_pixel) + int'(e_r_q) + int'(cur_err), ERR_W));
    q          = int'(pix_sum) >= int'(THRESH);
    pix_err    = ERR_W'(sat_err(int'(pix_sum) - (q ? PixMax : 0), ERR_W));
    t7         = ERR_W'(sat_err((7 * int'(pix_err)) >>> 4, ERR_W));
    t5         = ERR_W'(sat_err((5 * int'(pix_err)) >>> 4, ERR_W));
    t3         = ERR_W'(sat_err((3 * int'(pix_err)) >>> 4, ERR_W));
    t1         = ERR_W'(sat_err(int'(pix_err) >>> 4, ERR_W));
    nxt_sum    = ERR_W'(sat_err(int'(acc_bl_q) + int'(t3), ERR_W));
    acc_bl_new = ERR_W'(sat_err(int'(acc_b_q) + int'(t5), ERR_W));
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sel_d       = sel_q;
    e_r_d       = e_r_q;
    acc_b_d     = acc_b_q;
    acc_bl_d    = acc_bl_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    wr_en       = 1'b0;
    wr_bank     = ~sel_q;
    wr_addr     = x_q - 1'b1;
    wr_data     = nxt_sum;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_bit_d   = q;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StClear: begin
        wr_en   = 1'b1;
        wr_bank = sel_q;
        wr_addr = x_q;
        wr_data = '0;
        if (x_q == XLast) begin
          x_d     = '0;
          state_d = StRun;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          e_r_d    = (x_q == XLast) ? '0 : t7;
          acc_bl_d = acc_bl_new;
          acc_b_d  = (x_q == XLast) ? '0 : t1;
          // Bottom-left of x=0 falls outside the image.
          wr_en    = (x_q != '0);
          if (x_q == XLast) state_d = StRowEnd;
          else              x_d     = x_q + 1'b1;
        end
      end
      StRowEnd: begin
        wr_en    = 1'b1;
        wr_addr  = XLast;
        wr_data  = acc_bl_q;
        sel_d    = ~sel_q;
        x_d      = '0;
        e_r_d    = '0;
        acc_b_d  = '0;
        acc_bl_d = '0;
        if (y_q == YLast) begin
          state_d = StDrain;
        end else begin
          y_d     = y_q + 1'b1;
          state_d = StRun;
        end
      end
      StDrain: begin
        if (!out_valid_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      sel_q       <= 1'b0;
      e_r_q       <= '0;
      acc_b_q     <= '0;
      acc_bl_q    <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      e_r_q       <= e_r_d;
      acc_b_q     <= acc_b_d;
      acc_bl_q    <= acc_bl_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

endmodule

// File: tb/tb_fs_error_diffuser.sv
// Self-checking bench for fs_error_diffuser on a 4x2 image against a frame-level
// Floyd-Steinberg reference model.
module tb_fs_error_diffuser;

  localparam int X   = 4;
  localparam int Y   = 2;
  localparam int N   = X * Y;
  localparam int LIM = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       in_ready, trav_en, out_valid, out_bit, busy, done;

  fs_error_diffuser #(
    .IMAGEX  (X),
    .IMAGEY  (Y),
    .RGB_SIZE(8),
    .ERR_W   (11),
    .THRESH  (128)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .trav_en  (trav_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int frame_px[N];
  int model_bits[N];
  int got_bits[N];
  bit exp_q[$];
  int got_n, px_idx, trav_cnt, done_cnt, clr_cnt, stall_cnt;
  bit seen_run, stall_prev, stall_bit;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int sat(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  // Whole-frame reference: per row, quantise left to right carrying the right-hand
  // error, then build the row below from each pixel's 1/16, 5/16 and 3/16 shares.
  task automatic model_frame();
    int below[X];
    int nb[X];
    int t1[X];
    int t3[X];
    int t5[X];
    int right, v, e;
    bit qb;
    for (int i = 0; i < X; i++) below[i] = 0;
    exp_q.delete();
    for (int yy = 0; yy < Y; yy++) begin
      right = 0;
      for (int xx = 0; xx < X; xx++) begin
        v  = sat(frame_px[yy*X+xx] + right + below[xx]);
        qb = (v >= 128);
        model_bits[yy*X+xx] = int'(qb);
        exp_q.push_back(qb);
        e      = sat(v - (qb ? 255 : 0));
        right  = (xx == X - 1) ? 0 : sat((7 * e) >>> 4);
        t5[xx] = sat((5 * e) >>> 4);
        t3[xx] = sat((3 * e) >>> 4);
        t1[xx] = sat(e >>> 4);
      end
      for (int xx = 0; xx < X; xx++) begin
        nb[xx] = sat(sat(((xx > 0) ? t1[xx-1] : 0) + t5[xx]) + ((xx < X - 1) ? t3[xx+1] : 0));
      end
      below = nb;
    end
  endtask

  // Compare process: sampled mid-cycle, after the driver has settled the inputs.
  initial begin
    bit want;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        chk("trav_en_eq", int'(trav_en), int'(in_valid & in_ready));
        if (busy && !seen_run) begin
          if (in_ready) seen_run = 1'b1;
          else begin
            clr_cnt++;
            chk("clear_trav_en", int'(trav_en), 0);
          end
        end
        if (trav_en) begin
          px_idx++;
          trav_cnt++;
        end
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", int'(in_ready), 0);
          if (stall_prev) chk("stall_bit_stable", int'(out_bit), int'(stall_bit));
          stall_prev = 1'b1;
          stall_bit  = out_bit;
          stall_cnt++;
        end else begin
          if (stall_prev) chk("stall_valid_held", int'(out_valid), 1);
          stall_prev = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_out: got bit %0d with no pixel outstanding", out_bit);
          end else begin
            want = exp_q.pop_front();
            chk("out_bit", int'(out_bit), int'(want));
            if (got_n < N) got_bits[got_n] = int'(out_bit);
            got_n++;
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_trav_en"}, int'(trav_en), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_bit"}, int'(out_bit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run_frame(input bit rnd, input int hold_at, input int abort_at);
    int  cyc;
    int  hold_left;
    bit  held;
    bit  aborted;
    cyc = 0;
    hold_left = 0;
    held = 1'b0;
    aborted = 1'b0;
    model_frame();
    @(negedge clk);
    px_idx = 0; trav_cnt = 0; done_cnt = 0; got_n = 0;
    clr_cnt = 0; seen_run = 1'b0; stall_cnt = 0;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_pixel = 8'(frame_px[0]);
    forever begin
      @(negedge clk);
      cyc++;
      if (done_cnt != 0 || cyc > 300) break;
      if (abort_at >= 0 && px_idx == abort_at) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        #1;
        check_outputs_zero("abort");
        break;
      end
      start = rnd && busy && ($urandom_range(0, 7) == 0);
      if (hold_at >= 0 && px_idx == hold_at && !held) begin
        hold_left = 5;
        held = 1'b1;
      end
      if (hold_left > 0) begin
        hold_left--;
        in_valid  = 1'b1;
        out_ready = 1'b0;
      end else if (rnd) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
      in_pixel = (px_idx < N) ? 8'(frame_px[px_idx]) : 8'h00;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (cyc > 300) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got no done within 300 cycles, expected one");
    end
    if (aborted) begin
      repeat (2) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      rst_n = 1'b1;
      exp_q.delete();
    end else begin
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("trav_count", trav_cnt, N);
      chk("out_count", got_n, N);
      chk("exp_left", exp_q.size(), 0);
      chk("clear_len", clr_cnt, X);
      chk("idle_busy", int'(busy), 0);
    end
  endtask

  initial begin
    int exp64[N];
    exp64 = '{0, 0, 0, 0, 0, 1, 0, 1};

    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) frame_px[i] = 0;
    run_frame(1'b0, -1, -1);
    for (int i = 0; i < N; i++) chk("all0_bit", got_bits[i], 0);

    for (int i = 0; i < N; i++) frame_px[i] = 255;
    run_frame(1'b0, -1, -1);
    for (int i = 0; i < N; i++) chk("all255_bit", got_bits[i], 1);

    frame_px = '{128, 128, 0, 0, 0, 0, 0, 0};
    run_frame(1'b0, -1, -1);
    chk("pin128_model0", model_bits[0], 1);
    chk("pin128_model1", model_bits[1], 0);
    chk("pin128_dut0", got_bits[0], 1);
    chk("pin128_dut1", got_bits[1], 0);

    for (int i = 0; i < N; i++) frame_px[i] = int'($urandom_range(0, 255));
    run_frame(1'b0, 2, -1);
    chk("hold_stall_cycles", stall_cnt, 5);

    for (int i = 0; i < N; i++) frame_px[i] = 64;
    run_frame(1'b1, -1, -1);
    for (int i = 0; i < N; i++) begin
      chk("const64_model", model_bits[i], exp64[i]);
      chk("const64_dut", got_bits[i], exp64[i]);
    end

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) frame_px[i] = ($urandom_range(0, 1) == 1) ? 255 : 0;
        else frame_px[i] = int'($urandom_range(0, 255));
      end
      run_frame(1'b1, -1, -1);
    end

    for (int i = 0; i < N; i++) frame_px[i] = int'($urandom_range(0, 255));
    run_frame(1'b1, -1, 6);
    @(negedge clk);
    check_outputs_zero("post_abort");

    for (int i = 0; i < N; i++) frame_px[i] = int'($urandom_range(0, 255));
    run_frame(1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
